// File: rtl/bus_stream_server.sv
// bus_stream_server: responder on the rq/ack bus bridging bus accesses to two
// valid/ready streams.
//
//   DATA   (BASE_ADDR)   write pushes the TX FIFO (drained on m_*),
//                        read pops the RX FIFO (filled from s_*).
//   STATUS (BASE_ADDR+1) read: {rx_count[7:4], underflow, overflow, rx_empty, tx_full}.
//   CTRL   (BASE_ADDR+2) write: bit0 flush TX, bit1 flush RX, bit2 clear sticky flags.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   address, rq, wr_ni   bus request (wr_ni = 1 means write), dataW write data
//   ack, dataR           one-cycle completion pulse and registered read data
//   m_valid/m_ready/m_data   TX stream (head of TX FIFO)
//   s_valid/s_ready/s_data   RX stream into RX FIFO
//
// Optional build macro BUS_STREAM_SERVER_NONBLOCK_EN: DATA accesses never
// wait; writes to a full TX are dropped (overflow), reads from an empty RX
// return 0 (underflow). Without it, such accesses wait and the sticky flags
// read as 0.
module bus_stream_server #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  rq,
    output logic                  ack,
    input  logic                  wr_ni,
    input  logic [DATA_WIDTH-1:0] dataW,
    output logic [DATA_WIDTH-1:0] dataR,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [CntW-1:0]       DepthCnt   = CntW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] AddrData   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] AddrStatus = ADDR_WIDTH'(BASE_ADDR + 1);
    localparam logic [ADDR_WIDTH-1:0] AddrCtrl   = ADDR_WIDTH'(BASE_ADDR + 2);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e state_q;

    // FIFO storage and state
    logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [PtrW-1:0]       tx_wr_q, tx_rd_q;
    logic [CntW-1:0]       tx_cnt_q;
    logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
    logic [PtrW-1:0]       rx_wr_q, rx_rd_q;
    logic [CntW-1:0]       rx_cnt_q;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic sel_data, sel_status, sel_ctrl;
    logic in_req, blocked, commit;
    logic tx_push, tx_pop, tx_flush;
    logic rx_push, rx_pop, rx_flush;
    logic overflow_q, underflow_q;
    logic [DATA_WIDTH-1:0] status_word, rd_data;

    assign tx_full  = (tx_cnt_q == DepthCnt);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == DepthCnt);
    assign rx_empty = (rx_cnt_q == '0);

    assign sel_data   = (address == AddrData);
    assign sel_status = (address == AddrStatus);
    assign sel_ctrl   = (address == AddrCtrl);

    // rq is ignored during the ack cycle
    assign in_req = rq && (state_q != StAck);
    assign commit = in_req && !blocked;

    assign tx_push  = commit && sel_data && wr_ni && !tx_full;
    assign rx_pop   = commit && sel_data && !wr_ni && !rx_empty;
    assign tx_flush = commit && sel_ctrl && wr_ni && dataW[0];
    assign rx_flush = commit && sel_ctrl && wr_ni && dataW[1];

    assign m_valid = !tx_empty;
    assign m_data  = tx_mem[tx_rd_q];
    assign tx_pop  = m_valid && m_ready;

    assign s_ready = !rx_full;
    assign rx_push = s_valid && s_ready;

`ifdef BUS_STREAM_SERVER_NONBLOCK_EN
    logic sticky_clr;

    assign blocked    = 1'b0;
    assign sticky_clr = commit && sel_ctrl && wr_ni && dataW[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (sticky_clr) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (commit && sel_data && wr_ni && tx_full) begin
                overflow_q <= 1'b1;
            end
            if (commit && sel_data && !wr_ni && rx_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end
`else
    // A DATA access that cannot complete holds the bus until it can.
    assign blocked     = sel_data && (wr_ni ? tx_full : rx_empty);
    assign overflow_q  = 1'b0;
    assign underflow_q = 1'b0;
`endif

    always_comb begin
        status_word      = '0;
        status_word[0]   = tx_full;
        status_word[1]   = rx_empty;
        status_word[2]   = overflow_q;
        status_word[3]   = underflow_q;
        status_word[7:4] = 4'(rx_cnt_q);
    end

    // Writes and CTRL reads return 0; an empty RX read (non-blocking) returns 0.
    always_comb begin
        rd_data = '0;
        if (!wr_ni) begin
            if (sel_data && !rx_empty) begin
                rd_data = rx_mem[rx_rd_q];
            end else if (sel_status) begin
                rd_data = status_word;
            end
        end
    end

    // Bus FSM with registered ack/dataR; dataR holds between acks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ack     <= 1'b0;
            dataR   <= '0;
        end else begin
            ack <= 1'b0;
            case (state_q)
                StIdle, StWait: begin
                    if (in_req) begin
                        if (commit) begin
                            state_q <= StAck;
                            ack     <= 1'b1;
                            dataR   <= rd_data;
                        end else begin
                            state_q <= StWait;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StAck:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // TX FIFO: a handshake coinciding with a flush is still delivered.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_q] <= dataW;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || tx_flush) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_q <= tx_wr_q + PtrW'(1);
            end
            if (tx_pop) begin
                tx_rd_q <= tx_rd_q + PtrW'(1);
            end
            tx_cnt_q <= tx_cnt_q + CntW'(tx_push) - CntW'(tx_pop);
        end
    end

    // RX FIFO: a stream word arriving with a flush is discarded.
    always_ff @(posedge clk) begin
        if (rx_push && !rx_flush) begin
            rx_mem[rx_wr_q] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || rx_flush) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_q <= rx_wr_q + PtrW'(1);
            end
            if (rx_pop) begin
                rx_rd_q <= rx_rd_q + PtrW'(1);
            end
            rx_cnt_q <= rx_cnt_q + CntW'(rx_push) - CntW'(rx_pop);
        end
    end

endmodule

// File: tb/tb_bus_stream_server.sv
// Scoreboard bench for bus_stream_server (default parameters: 8-bit data,
// 4-bit address, depth 4, base 0). Drivers push expected bus read data and
// expected TX stream words into queues; a negedge monitor pops and compares
// on every ack and every m_* handshake.
module tb_bus_stream_server;

    localparam logic [3:0] A_DATA   = 4'd0;
    localparam logic [3:0] A_STATUS = 4'd1;
    localparam logic [3:0] A_CTRL   = 4'd2;
    localparam logic [3:0] A_UNMAP  = 4'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] address;
    logic       rq;
    logic       ack;
    logic       wr_ni;
    logic [7:0] dataW;
    logic [7:0] dataR;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_bus_q[$];
    logic [7:0] exp_tx_q[$];

    bus_stream_server dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .rq      (rq),
        .ack     (ack),
        .wr_ni   (wr_ni),
        .dataW   (dataW),
        .dataR   (dataR),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares at negedge, away from the active edge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (ack === 1'b1) begin
                if (exp_bus_q.size() == 0) check("unexpected_ack", ack, 1'b0);
                else check("bus_dataR", dataR, exp_bus_q.pop_front());
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                if (exp_tx_q.size() == 0) check("unexpected_m_beat", m_valid, 1'b0);
                else check("m_data", m_data, exp_tx_q.pop_front());
            end
        end
    end

    // One bus access; exp_lat = 0 skips the latency check. Returns latency.
    task automatic bus_access(input logic [3:0] addr, input logic wr, input logic [7:0] wdata,
                              input logic [7:0] exp_rd, input int exp_lat, input string name,
                              output int lat);
        bit got;
        exp_bus_q.push_back(wr ? 8'h00 : exp_rd);
        @(posedge clk); #2;
        address = addr;
        wr_ni   = wr;
        dataW   = wdata;
        rq      = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ack === 1'b1) got = 1'b1;
        end
        check({"ack_seen_", name}, 32'(got), 32'd1);
        if (!got) void'(exp_bus_q.pop_back());
        else if (exp_lat > 0) check({"ack_latency_", name}, lat, exp_lat);
        @(posedge clk); #2;
        rq = 1'b0;
        @(negedge clk);
        check({"ack_pulse_", name}, 32'(ack), 32'd0);
    endtask

    task automatic bus_rd(input logic [3:0] addr, input logic [7:0] exp_rd, input string name);
        int lat;
        bus_access(addr, 1'b0, 8'h00, exp_rd, 1, name, lat);
    endtask

    task automatic bus_wr(input logic [3:0] addr, input logic [7:0] wdata, input string name);
        int lat;
        bus_access(addr, 1'b1, wdata, 8'h00, 1, name, lat);
    endtask

    task automatic s_push(input logic [7:0] d);
        int waited;
        @(posedge clk); #2;
        s_valid = 1'b1;
        s_data  = d;
        waited  = 0;
        @(negedge clk);
        while (s_ready !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check("s_push_accepted", 32'(s_ready), 32'd1);
        @(posedge clk); #2;
        s_valid = 1'b0;
    endtask

    // Release m_ready, allow `cycles` beats, then expect TX drained.
    task automatic drain_tx(input int cycles, input string name);
        @(posedge clk); #2;
        m_ready = 1'b1;
        repeat (cycles) @(negedge clk);
        check({"tx_drained_", name}, 32'(exp_tx_q.size()), 32'd0);
        check({"m_valid_idle_", name}, 32'(m_valid), 32'd0);
        @(posedge clk); #2;
        m_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int lat;
        int acks;
        reset   = 1'b1;
        rq      = 1'b0;
        address = '0;
        wr_ni   = 1'b0;
        dataW   = '0;
        m_ready = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dataR", 32'(dataR), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #2;
        reset = 1'b0;

        bus_rd(A_STATUS, 8'h02, "status_reset");

        // TX path: three writes held back, then consecutive delivery
        bus_wr(A_DATA, 8'hA1, "wr_a1");
        bus_wr(A_DATA, 8'hA2, "wr_a2");
        bus_wr(A_DATA, 8'hA3, "wr_a3");
        check("m_valid_held", 32'(m_valid), 32'd1);
        check("m_data_head", 32'(m_data), 32'hA1);
        exp_tx_q.push_back(8'hA1);
        exp_tx_q.push_back(8'hA2);
        exp_tx_q.push_back(8'hA3);
        drain_tx(4, "a");

        // RX path: fill to depth, read back in order
        for (int i = 0; i < 4; i++) s_push(8'h11 + 8'(i));
        @(negedge clk);
        check("s_ready_full", 32'(s_ready), 32'd0);
        bus_rd(A_STATUS, 8'h40, "status_rx_full");
        bus_rd(A_DATA, 8'h11, "rd_11");
        check("s_ready_after_pop", 32'(s_ready), 32'd1);
        bus_rd(A_DATA, 8'h12, "rd_12");
        bus_rd(A_DATA, 8'h13, "rd_13");
        bus_rd(A_DATA, 8'h14, "rd_14");
        bus_rd(A_STATUS, 8'h02, "status_rx_drained");

        // CTRL / unmapped decode
        bus_rd(A_CTRL, 8'h00, "ctrl_read");
        bus_wr(A_UNMAP, 8'hFF, "unmap_write");
        bus_rd(A_UNMAP, 8'h00, "unmap_read");
        bus_wr(A_STATUS, 8'hFF, "status_write");

        // Flushes
        bus_wr(A_DATA, 8'hC1, "wr_c1");
        bus_wr(A_DATA, 8'hC2, "wr_c2");
        bus_wr(A_CTRL, 8'h01, "flush_tx");
        check("m_valid_after_flush", 32'(m_valid), 32'd0);
        s_push(8'hD1);
        s_push(8'hD2);
        bus_rd(A_STATUS, 8'h20, "status_rx_two");
        bus_wr(A_CTRL, 8'h02, "flush_rx");
        bus_rd(A_STATUS, 8'h02, "status_rx_flushed");

`ifdef BUS_STREAM_SERVER_NONBLOCK_EN
        // Non-blocking: overflow and underflow
        for (int i = 0; i < 5; i++) bus_wr(A_DATA, 8'hB1 + 8'(i), "wr_nb");
        bus_rd(A_STATUS, 8'h07, "status_overflow");
        for (int i = 0; i < 4; i++) exp_tx_q.push_back(8'hB1 + 8'(i));
        drain_tx(8, "b");
        bus_rd(A_STATUS, 8'h06, "status_overflow_kept");
        bus_wr(A_CTRL, 8'h04, "clr_sticky");
        bus_rd(A_STATUS, 8'h02, "status_cleared");
        bus_rd(A_DATA, 8'h00, "rd_empty_nb");
        bus_rd(A_STATUS, 8'h0A, "status_underflow");
        bus_wr(A_CTRL, 8'h04, "clr_sticky2");
        bus_rd(A_STATUS, 8'h02, "status_cleared2");
`else
        // Blocking read waits until the stream supplies a word
        fork
            bus_access(A_DATA, 1'b0, 8'h00, 8'h5C, 0, "rd_wait", lat);
            begin
                repeat (6) @(posedge clk);
                s_push(8'h5C);
            end
        join
        check("rd_wait_latency", lat, 8);
        bus_rd(A_STATUS, 8'h02, "status_after_wait");

        // Reset while a write to a full TX is pending
        for (int i = 0; i < 4; i++) bus_wr(A_DATA, 8'hE1 + 8'(i), "wr_fill");
        bus_rd(A_STATUS, 8'h03, "status_tx_full");
        @(posedge clk); #2;
        address = A_DATA;
        wr_ni   = 1'b1;
        dataW   = 8'hE5;
        rq      = 1'b1;
        acks    = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        check("wait_no_ack", acks, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        rq    = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("wait_rst_ack", 32'(ack), 32'd0);
        check("wait_rst_m_valid", 32'(m_valid), 32'd0);
        bus_rd(A_STATUS, 8'h02, "status_after_reset");
`endif

        bus_wr(A_DATA, 8'h77, "wr_77");
        check("m_data_77", 32'(m_data), 32'h77);
        exp_tx_q.push_back(8'h77);
        drain_tx(3, "c");

        repeat (3) @(negedge clk);
        check("bus_sb_empty", 32'(exp_bus_q.size()), 32'd0);
        check("tx_sb_empty", 32'(exp_tx_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_stream_server.md
Name: bus_stream_server

Overview:
- Responder (server end) of the rq/ack bus, placed behind the bus arbiter's server port in place of, or beside, the RAM.
- Bridges bus accesses to two valid/ready streams:
  - bus writes to DATA push a TX FIFO, which is drained on the m_* stream;
  - bus reads from DATA pop an RX FIFO, which is filled from the s_* stream.
- STATUS and CTRL registers expose FIFO state and flush/clear controls.

Parameters:
- DATA_WIDTH, 8, bus and stream word width; must be at least 8.
- ADDR_WIDTH, 4, bus address width.
- FIFO_DEPTH, 4, entries per FIFO; legal values are 2, 4, 8.
- BASE_ADDR, 0, DATA is at BASE_ADDR, STATUS at BASE_ADDR+1, CTRL at BASE_ADDR+2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_WIDTH  bus address; stable while rq is high.
- rq  in  1  bus request, held high until ack is seen.
- ack  out  1  one-cycle completion pulse.
- wr_ni  in  1  1 = write, 0 = read.
- dataW  in  DATA_WIDTH  write data.
- dataR  out  DATA_WIDTH  read data; valid in the ack cycle.
- m_valid  out  1  TX stream valid.
- m_ready  in  1  TX stream ready.
- m_data  out  DATA_WIDTH  TX stream data (TX FIFO head).
- s_valid  in  1  RX stream valid.
- s_ready  out  1  RX stream ready.
- s_data  in  DATA_WIDTH  RX stream data.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: ack=0, dataR=0, state=IDLE, both FIFOs empty, sticky flags 0, m_valid=0, s_ready=1.
- Reset mid-transaction: the access is dropped with no ack, and FIFO contents are lost.
- FSM states: IDLE, WAIT, ACK.
- IDLE, rq=1 sampled at edge t:
  - if the access is serviceable, it commits at t, ack and dataR are registered at t, and the state goes to ACK. ack is therefore high in the cycle after rq is first seen (1-cycle latency).
  - if the access is not serviceable, the state goes to WAIT.
- WAIT: re-evaluates every cycle and completes as in IDLE once serviceable. address, wr_ni and dataW must stay stable.
- ACK: ack is high for exactly one cycle and rq is ignored. Next state is IDLE, with ack=0. The initiator must drop rq, or present a new access no earlier than the cycle after ack.
- Serviceability:
  - DATA write: TX not full.
  - DATA read: RX not empty.
  - All other accesses are always serviceable.
- DATA write pushes dataW into TX. DATA read returns the RX head in dataR and pops RX.
- STATUS read returns:
  - bit0: TX full.
  - bit1: RX empty.
  - bit2: overflow (sticky).
  - bit3: underflow (sticky).
  - bits7:4: RX count (0..FIFO_DEPTH).
  - upper bits: 0.
- STATUS write is ignored and acked.
- CTRL write:
  - bit0 flushes TX.
  - bit1 flushes RX.
  - bit2 clears the sticky flags.
  - Bits take effect at the commit edge.
- CTRL read returns 0.
- Unmapped address: read returns 0, write is ignored, ack as normal.
- dataR holds its last value outside ack cycles. For writes it is 0 in the ack cycle.
- TX stream:
  - m_valid = TX not empty; m_data = TX head.
  - Pop on m_valid and m_ready.
  - A bus push and a stream pop in the same cycle leave the count unchanged.
  - Push into a full FIFO during a same-cycle pop is not allowed (a full write waits).
- RX stream:
  - s_ready = RX not full, from the registered count.
  - Push on s_valid and s_ready.
  - Simultaneous stream push and bus pop are both performed.
- Flush collisions:
  - TX flush in the same cycle as an m_* handshake: the handshaken word counts as delivered, and TX ends empty.
  - RX flush in the same cycle as an s_* handshake: the incoming word is discarded, and RX ends empty.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Counts are log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: BUS_STREAM_SERVER_NONBLOCK_EN.
- Defined:
  - DATA write to a full TX is dropped, acked with 1-cycle latency, and sets overflow.
  - DATA read from an empty RX returns 0, is acked with 1-cycle latency, and sets underflow.
  - WAIT state is never entered.
- Undefined:
  - blocking behaviour as above.
  - sticky bits are tied to 0.
  - CTRL bit2 has no effect.

Test Plan:
- Reset, then STATUS read: ack 1 cycle after rq; dataR=0x02 (RX empty, count 0); m_valid=0; s_ready=1.
- Bus writes 0xA1, 0xA2, 0xA3 to DATA with m_ready=0: each acked in 1 cycle; m_data=0xA1. Then set m_ready=1: 0xA1, 0xA2, 0xA3 appear on consecutive cycles, then m_valid=0.
- Stream in 0x11..0x14 (DEPTH=4): s_ready drops after the 4th word; STATUS=0x40; four DATA reads return 0x11..0x14; s_ready returns to 1 after the first pop.
- Blocking mode, DATA read with RX empty: no ack while waiting. Drive s_data=0x5C for one cycle; ack follows with dataR=0x5C; RX count back to 0.
- NONBLOCK_EN defined, five DATA writes with m_ready=0 and DEPTH=4: all five acked; STATUS bit2=1; m_* later delivers only the first four words. CTRL write 0x04 clears bit2.
- Assert reset while in WAIT (TX full, write pending): no ack, TX empty, m_valid=0. A new write of 0x77 after reset is acked in 1 cycle and appears on m_data.
